// File: rtl/lane_os_pkg.sv
// lane_os_pkg: shared codes, constants and state types for the lane ordered-set generator
package lane_os_pkg;
  localparam logic [3:0] D_SEL_IDLE  = 4'd0;
  localparam logic [3:0] D_SEL_SLOS1 = 4'd1;
  localparam logic [3:0] D_SEL_SLOS2 = 4'd2;
  localparam logic [3:0] D_SEL_TS1   = 4'd3;
  localparam logic [3:0] D_SEL_TS2   = 4'd4;
  localparam logic [3:0] D_SEL_TS3   = 4'd5;
  localparam logic [3:0] D_SEL_TS4   = 4'd6;
  localparam logic [7:0] OS_START_BYTE = 8'hBC;
  localparam logic [3:0] OS_HDR_NIBBLE = 4'h5;
  typedef enum logic [3:0] {
    OS_NONE  = 4'd0,
    OS_SLOS1 = 4'd1,
    OS_SLOS2 = 4'd2,
    OS_TS1   = 4'd3,
    OS_TS2   = 4'd4,
    OS_TS3   = 4'd5,
    OS_TS4   = 4'd6
  } os_code_t;
  typedef enum logic {IDLE, SEND} os_state_t;
  function automatic logic is_valid_code(input logic [3:0] c);
    return c >= D_SEL_SLOS1 && c <= D_SEL_TS4;
  endfunction
endpackage

// File: rtl/lane_os_generator_os_byte_former.sv
// os_byte_former: combinational byte and running-check former for one lane (check byte enabled by LANE_OS_CHECK_EN)
module os_byte_former
  import lane_os_pkg::*;
#(
  parameter int OS_LEN = 8
) (
  input  os_code_t   code,
  input  logic       lane,
  input  logic [2:0] rep,
  input  logic [3:0] byte_idx,
  input  logic [7:0] acc,
  output logic [7:0] os_byte,
  output logic [7:0] acc_next
);
  logic [7:0] chk;
`ifdef LANE_OS_CHECK_EN
  assign chk = acc;
`else
  assign chk = 8'h00;
`endif
  // pick the framing, header, payload or check byte; fold it into the running check
  always_comb begin
    os_byte = byte_idx == 4'd0 ? OS_START_BYTE :
              byte_idx == 4'd1 ? {OS_HDR_NIBBLE, code} :
              byte_idx == 4'(OS_LEN - 1) ? chk : {lane, rep, byte_idx};
    acc_next = byte_idx == 4'd0 ? 8'h00 : acc ^ os_byte;
  end
endmodule

// File: rtl/lane_os_generator.sv
// lane_os_generator: serialises framed ordered-set bursts onto a lane pair (check byte enabled by LANE_OS_CHECK_EN)
module lane_os_generator
  import lane_os_pkg::*;
#(
  parameter int OS_LEN    = 8,
  parameter int OS_REPEAT = 2
) (
  input  logic       fsm_clk,
  input  logic       rst,
  input  logic [3:0] d_sel,
  output logic [7:0] lane_0_tx,
  output logic [7:0] lane_1_tx,
  output logic       tx_lanes_on,
  output logic       os_sent
);
  os_state_t  state, state_n;
  os_code_t   code, code_n;
  logic [3:0] byte_idx, byte_n;
  logic [2:0] rep, rep_n;
  logic [7:0] acc_0, acc_1, acc_0_n, acc_1_n, byte_0, byte_1;
  logic       last, start, send;
  os_byte_former #(.OS_LEN(OS_LEN)) u_l0 (
    .code(code), .lane(1'b0), .rep(rep), .byte_idx(byte_idx),
    .acc(acc_0), .os_byte(byte_0), .acc_next(acc_0_n)
  );
  os_byte_former #(.OS_LEN(OS_LEN)) u_l1 (
    .code(code), .lane(1'b1), .rep(rep), .byte_idx(byte_idx),
    .acc(acc_1), .os_byte(byte_1), .acc_next(acc_1_n)
  );
  // next state: d_sel is only sampled in IDLE or on the final byte of a burst
  always_comb begin
    send = state == SEND;
    last = send && byte_idx == 4'(OS_LEN - 1) && rep == 3'(OS_REPEAT - 1);
    start = is_valid_code(d_sel) && (!send || last);
    state_n = (start || (send && !last)) ? SEND : IDLE;
    code_n = start ? os_code_t'(d_sel) : code;
    byte_n = (!send || byte_idx == 4'(OS_LEN - 1)) ? 4'd0 : byte_idx + 4'd1;
    rep_n = (!send || last) ? 3'd0 : byte_idx == 4'(OS_LEN - 1) ? rep + 3'd1 : rep;
  end
  // state, counters, check accumulators and registered lane outputs
  always_ff @(posedge fsm_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      code <= OS_NONE;
      byte_idx <= 4'd0;
      rep <= 3'd0;
      acc_0 <= 8'h00;
      acc_1 <= 8'h00;
      lane_0_tx <= 8'h00;
      lane_1_tx <= 8'h00;
      tx_lanes_on <= 1'b0;
      os_sent <= 1'b0;
    end else begin
      state <= state_n;
      code <= code_n;
      byte_idx <= byte_n;
      rep <= rep_n;
      acc_0 <= send ? acc_0_n : 8'h00;
      acc_1 <= send ? acc_1_n : 8'h00;
      lane_0_tx <= send ? byte_0 : 8'h00;
      lane_1_tx <= send ? byte_1 : 8'h00;
      tx_lanes_on <= send;
      os_sent <= last;
    end
  end
endmodule

// File: doc/lane_os_generator.md
# lane_os_generator

Transmit-side ordered-set generator for the USB4 logical layer lane pair. On an ordered-set request encoded on `d_sel`, it serialises framed ordered sets byte-by-byte onto lane 0 and lane 1, repeats them a configured number of times, and pulses `os_sent` on completion. It is the sending end of the ordered sets that the receive data path decodes into `os_in_l0`/`os_in_l1`, and sits between the lane-training FSM and the lane transmit mux.

## Interface
- `OS_LEN`, 8: bytes per ordered set per lane; legal range 4..16.
- `OS_REPEAT`, 2: ordered sets per burst; legal range 1..8.
- `fsm_clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `d_sel` in 4: request code: 0 = idle, 1 = SLOS1, 2 = SLOS2, 3 = TS1, 4 = TS2, 5 = TS3, 6 = TS4; codes 7..15 are treated as idle.
- `lane_0_tx` out 8: lane 0 transmit byte.
- `lane_1_tx` out 8: lane 1 transmit byte.
- `tx_lanes_on` out 1: high while a byte of an ordered set is driven.
- `os_sent` out 1: one-cycle pulse marking the end of a burst.

## Operation
- FSM states: IDLE and SEND. Counters: `byte_idx` (0..OS_LEN-1) and `rep` (0..OS_REPEAT-1). Latched `code` register.
- IDLE: samples `d_sel` each cycle. A valid code 1..6 latches `code`, clears the counters and enters SEND. Outputs are 0.
- SEND: one byte per lane per cycle. Lane id `L` is 0 for lane 0 and 1 for lane 1. Bytes per ordered set:
  - byte 0 = 8'hBC.
  - byte 1 = {4'h5, code}.
  - bytes 2..OS_LEN-2 = {L, rep[2:0], byte_idx[3:0]}.
  - byte OS_LEN-1 = check byte (see Configuration).
- At the last byte, `rep` increments and `byte_idx` wraps to 0.
- At the last byte of the last repetition:
  - `os_sent` = 1.
  - `d_sel` is re-sampled. The same valid code starts a new burst the next cycle with no gap and `rep` = 0. A different valid code is latched and its burst starts the next cycle. Idle or an invalid code returns the FSM to IDLE.
- Changes of `d_sel` during SEND are ignored until that final byte. A burst is never truncated.
- Reset at any point, including mid-burst: FSM goes to IDLE, counters and `code` clear. All outputs go to 0 asynchronously.

## Timing
- Reset values: `lane_0_tx` = 8'h00, `lane_1_tx` = 8'h00, `tx_lanes_on` = 0, `os_sent` = 0.
- All outputs are registered.
- Latency: `d_sel` is sampled valid at edge N. Byte 0 appears after edge N+1, and `tx_lanes_on` rises in the same cycle.
- Burst length: OS_LEN × OS_REPEAT cycles. `tx_lanes_on` stays high for the whole burst.
- `os_sent` is high only in the cycle the final check byte is driven.
- Back-to-back bursts keep `tx_lanes_on` continuously high. `os_sent` pulses once per burst.
- Lanes are byte-aligned: both lanes always carry the same `byte_idx`.

## Configuration
- `LANE_OS_CHECK_EN` defined: check byte = XOR of bytes 1..OS_LEN-2 of the same lane and same repetition.
- `LANE_OS_CHECK_EN` undefined: check byte = 8'h00. All other behaviour is identical.

## Structure
- Shared package `lane_os_pkg`:
  - `d_sel` code localparams and the `os_code_t` type.
  - `OS_START_BYTE` = 8'hBC and `OS_HDR_NIBBLE` = 4'h5.
  - A function that validates a code (1..6).
- One sub-module, `os_byte_former`. It is combinational: from (`code`, `L`, `rep`, `byte_idx`) it forms the byte and the running check value. It is instantiated once per lane. The check accumulator register stays in the parent.

## Test plan
All scenarios use OS_LEN = 8, OS_REPEAT = 2 and `LANE_OS_CHECK_EN` defined unless noted.
- Reset then idle: `rst` low, then high with `d_sel` = 0 for 20 cycles → all outputs stay 0.
- TS1 single burst: `d_sel` = 3 for one cycle, then 0.
  - Lane 0, rep 0: BC,53,02,03,04,05,06,55.
  - Lane 1, rep 0: BC,53,82,83,84,85,86,D5.
  - Lane 0, rep 1: BC,53,12..16,45.
  - `os_sent` is high only on cycle 16 of the burst. `tx_lanes_on` falls after it.
- Continuous: `d_sel` held at 4 → bursts back-to-back, `tx_lanes_on` never drops, `os_sent` pulses every 16 cycles, byte 1 = 54.
- Mid-burst change: `d_sel` switches 3 → 5 at byte 5 of rep 0 → the TS1 burst completes unchanged, then a TS3 burst (byte 1 = 55) starts the next cycle.
- Reset mid-burst: `rst` asserted at byte 3 of rep 1 → outputs 0 immediately. After release with `d_sel` = 1, a fresh burst starts at rep 0.
- Macro off and invalid code: build without `LANE_OS_CHECK_EN` → byte 7 = 00. Separately, `d_sel` = 9 → FSM stays in IDLE with outputs 0.
